inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two and at least 2.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clock.
REQ-004 SHALL have port flush, input, 1, redirect from execute stage; discards all queued entries.
REQ-005 SHALL have port in_valid, input, 1, fetch stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1, queue can accept an instruction.
REQ-007 SHALL have port in_pc, input, 64, PC of the fetched instruction.
REQ-008 SHALL have port in_inst, input, 32, fetched instruction word.
REQ-009 SHALL have port out_valid, output, 1, head entry available to decode.
REQ-010 SHALL have port out_ready, input, 1, decode consumes the head entry.
REQ-011 SHALL have port out_pc, output, 64, PC of the head entry.
REQ-012 SHALL have port out_inst, output, 32, instruction word of the head entry.
REQ-013 SHALL have port out_is_ctrl, output, 1, head is JAL, JALR or BRANCH.
REQ-014 SHALL have port out_illegal, output, 1, head has inst[1:0] != 2'b11 (compressed instructions unsupported).
REQ-015 SHALL have port count, output, log2(DEPTH)+1, number of valid entries.

Function
REQ-016 SHALL push on a clock edge when in_valid and in_ready are both 1; pop when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = (count < DEPTH) and not flush; in_ready SHALL NOT depend on out_ready (no same-cycle pop-to-push when full).
REQ-018 SHALL drive out_valid = (count != 0) and not flush.
REQ-019 SHALL have no bypass: an entry pushed at edge N is visible at the outputs from cycle N+1; minimum latency 1 cycle.
REQ-020 SHALL allow a simultaneous push and pop with count unchanged, FIFO order preserved.
REQ-021 SHALL use read/write pointers of log2(DEPTH)+1 bits; they wrap modulo 2*DEPTH; full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
REQ-022 SHALL predecode out_is_ctrl from the head opcode: 1101111, 1100111 or 1100011; otherwise 0.
REQ-023 SHALL compute out_is_ctrl and out_illegal only from the stored word; they are don't-care when out_valid = 0.
REQ-024 SHALL, when flush = 1 at an edge, set count and both pointers to 0; a push or pop requested in that cycle SHALL be dropped.
REQ-025 SHALL ignore in_valid while full and ignore out_ready while empty, with no state change.
REQ-026 SHALL leave stored entries unchanged except on a write to that slot.

Reset
REQ-027 SHALL, with reset = 1 at an edge, clear count and both pointers, giving out_valid = 0 and in_ready = 1 in the next cycle.
REQ-028 SHALL give reset priority over flush, push and pop, including reset asserted while the queue is full.
REQ-029 SHALL NOT reset the entry storage; out_pc and out_inst are don't-care while out_valid = 0.

Structure
REQ-030 SHALL place the RV64 opcode constants (OP_JAL, OP_JALR, OP_BRANCH) and the default DEPTH in the shared core package.
REQ-031 SHALL implement predecode as the combinational sub-module inst_predecode (inst in; is_ctrl and illegal out).
REQ-032 SHALL hold entry storage in a single pc+inst array of DEPTH entries; no other sub-modules.

Verification
REQ-033 SHALL cover reset: hold reset 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1 the cycle after release.
REQ-034 SHALL cover ordering and fill: push pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C with out_ready = 0 -> count = 4 and in_ready = 0; then out_ready = 1 -> pcs emerge in order over 4 cycles.
REQ-035 SHALL cover simultaneous push/pop: count = 2, push and pop in the same cycle for 10 cycles -> count stays 2 and no entry is lost across pointer wrap.
REQ-036 SHALL cover flush: count = 3 with flush = 1 and in_valid = 1 -> next cycle count = 0, out_valid = 0, and the pushed entry is absent.
REQ-037 SHALL cover predecode: push 0x0000006F, 0x00008067, 0x00000063, 0x00000013, 0x00000001 -> out_is_ctrl = 1,1,1,0,0 and out_illegal = 0,0,0,0,1.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared core constants for the fetch-to-decode instruction queue:
// RV64 control-flow opcodes, default depth and the stored entry layout.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 4;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  function automatic logic is_ctrl_opcode(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/inst_predecode.sv
// Combinational predecode of a stored instruction word for the decode stage.
module inst_predecode
  import inst_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_ctrl,
  output logic        illegal
);

  assign is_ctrl = is_ctrl_opcode(inst[6:0]);
  // Compressed encodings are not supported, so anything without 2'b11 low bits is illegal.
  assign illegal = (inst[1:0] != 2'b11);

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with flush, pointer-based occupancy
// and predecoded control-flow / illegal flags on the head entry.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_pc,
  input  logic [31:0]             in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic                    out_is_ctrl,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Handshake: a transfer happens at a rising edge when valid and ready are both 1;
  // ready never depends on the partner's valid, and flush withdraws both sides.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  iq_entry_t   mem_q [DEPTH];
  iq_entry_t   mem_d [DEPTH];

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  iq_entry_t head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = '{pc: in_pc, inst: in_inst};
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  // Storage is deliberately outside reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign out_pc   = head.pc;
  assign out_inst = head.inst;

  inst_predecode u_predecode (
    .inst    (head.inst),
    .is_ctrl (out_is_ctrl),
    .illegal (out_illegal)
  );

endmodule
